// File: rtl/key_debounce_multi_if.sv
// Key front-end bundle: raw keys and counter clears in, debounced levels,
// event strobes and packed press counters out.
interface key_debounce_multi_if #(
  parameter int NUM_KEYS = 4,
  parameter int CNT_W    = 4
);
  logic [NUM_KEYS-1:0]       key_in;
  logic [NUM_KEYS-1:0]       clr_sum;
  logic [NUM_KEYS-1:0]       key_state;
  logic [NUM_KEYS-1:0]       press_pulse;
  logic [NUM_KEYS-1:0]       release_pulse;
  logic [NUM_KEYS-1:0]       long_pulse;
  logic [NUM_KEYS*CNT_W-1:0] sum;

  modport master (
    output key_in, clr_sum,
    input  key_state, press_pulse, release_pulse, long_pulse, sum
  );

  modport slave (
    input  key_in, clr_sum,
    output key_state, press_pulse, release_pulse, long_pulse, sum
  );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button front end: per key a 2-FF synchroniser, a debounce
// FSM with press/release/long-press strobes, and a wrapping press counter.
module key_debounce_multi #(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_debounce_multi_if.slave  bus
);

  localparam int DB_CYC   = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC = CLK_FREQ_HZ / 1000 * LONG_MS;
  localparam int MAX_CYC  = (DB_CYC > LONG_CYC) ? DB_CYC : LONG_CYC;
  localparam int TMR_W    = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] DB_LAST   = TMR_W'(DB_CYC - 1);
  localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYC - 1);
  localparam logic [TMR_W-1:0] LONG_SAT  = TMR_W'(LONG_CYC);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (NUM_KEYS < 1 || DB_CYC < 2 || LONG_CYC <= DB_CYC) begin : g_bad_params
    $error("key_debounce_multi: need NUM_KEYS>=1, DB_CYC>=2 and LONG_CYC>DB_CYC");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WT,
    PRESSED,
    REL_WT
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    logic             sync_a;
    logic             sync_b;
    state_t           state;
    state_t           state_nx;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nx;
    logic             level;
    logic             level_nx;
    logic             press;
    logic             press_nx;
    logic             rel;
    logic             rel_nx;
    logic             lng;
    logic             lng_nx;
    logic [CNT_W-1:0] cnt;

    // Sync chain resets to 1 so a reset looks like a released key, never a press.
    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_a <= 1'b1;
        sync_b <= 1'b1;
      end else begin
        sync_a <= bus.key_in[i];
        sync_b <= sync_a;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        tmr   <= '0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
        lng   <= 1'b0;
      end else begin
        state <= state_nx;
        tmr   <= tmr_nx;
        level <= level_nx;
        press <= press_nx;
        rel   <= rel_nx;
        lng   <= lng_nx;
      end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
      state_nx = state;
      tmr_nx   = tmr;
      level_nx = level;
      press_nx = 1'b0;
      rel_nx   = 1'b0;
      lng_nx   = 1'b0;
      case (state)
        IDLE: begin
          level_nx = 1'b0;
          if (!sync_b) begin
            state_nx = PRESS_WT;
            tmr_nx   = TMR_ONE;
          end else begin
            tmr_nx = '0;
          end
        end
        PRESS_WT: begin
          if (sync_b) begin
            state_nx = IDLE;
            tmr_nx   = '0;
          end else if (tmr == DB_LAST) begin
            state_nx = PRESSED;
            tmr_nx   = '0;
            press_nx = 1'b1;
            level_nx = 1'b1;
          end else begin
            tmr_nx = tmr + 1'b1;
          end
        end
        PRESSED: begin
          level_nx = 1'b1;
          if (sync_b) begin
            state_nx = REL_WT;
            tmr_nx   = TMR_ONE;
          end else if (tmr < LONG_SAT) begin
            // Saturating at LONG_CYC makes the long strobe fire once per hold.
            tmr_nx = tmr + 1'b1;
            lng_nx = (tmr == LONG_LAST);
          end
        end
        REL_WT: begin
          if (!sync_b) begin
            state_nx = PRESSED;
            tmr_nx   = '0;
          end else if (tmr == DB_LAST) begin
            state_nx = IDLE;
            tmr_nx   = '0;
            rel_nx   = 1'b1;
            level_nx = 1'b0;
          end else begin
            tmr_nx = tmr + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          tmr_nx   = '0;
          level_nx = 1'b0;
        end
      endcase
    end

    // A clear coinciding with an accepted press leaves that press counted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (bus.clr_sum[i]) begin
        cnt <= press ? CNT_ONE : '0;
      end else if (press) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign bus.key_state[i]             = level;
    assign bus.press_pulse[i]           = press;
    assign bus.release_pulse[i]         = rel;
    assign bus.long_pulse[i]            = lng;
    assign bus.sum[i*CNT_W +: CNT_W]    = cnt;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed scenarios plus random key traffic,
// checked by a run-length reference model feeding an event scoreboard.
module tb_key_debounce_multi;
  localparam int NK = 4;
  localparam int CW = 4;
  localparam int DB = 5;
  localparam int LG = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_debounce_multi_if #(.NUM_KEYS(NK), .CNT_W(CW)) bus ();

  key_debounce_multi #(
    .NUM_KEYS   (NK),
    .CLK_FREQ_HZ(1000),
    .DEBOUNCE_MS(5),
    .LONG_MS    (20),
    .CNT_W      (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keys are judged on the input sampled two edges earlier. A level change is
  // accepted once DB consecutive samples disagree with the current level; a
  // press held LG edges without any high sample produces one long event.
  typedef struct {
    int            cyc;
    logic [NK-1:0] p;
    logic [NK-1:0] r;
    logic [NK-1:0] l;
  } ev_t;

  ev_t           q[$];
  int            cyc = 0;
  logic [NK-1:0] smp1 = '1;
  logic [NK-1:0] smp2 = '1;
  logic [NK-1:0] lvl  = '0;
  logic [NK-1:0] ep   = '0;
  int            run[NK];
  int            hold[NK];
  int            esum[NK];
  logic [NK-1:0] np, nr, nl;
  logic          down;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp1 = '1;
      smp2 = '1;
      lvl  = '0;
      ep   = '0;
      for (int i = 0; i < NK; i++) begin
        run[i]  = 0;
        hold[i] = 0;
        esum[i] = 0;
      end
      q.delete();
    end else begin
      cyc++;
      np = '0;
      nr = '0;
      nl = '0;
      for (int i = 0; i < NK; i++) begin
        down = !smp2[i];
        if (bus.clr_sum[i]) esum[i] = ep[i] ? 1 : 0;
        else if (ep[i])     esum[i] = (esum[i] + 1) % (1 << CW);
        if (!lvl[i]) begin
          if (down) begin
            run[i]++;
            if (run[i] == DB) begin
              lvl[i] = 1'b1; run[i] = 0; hold[i] = 0; np[i] = 1'b1;
            end
          end else begin
            run[i] = 0;
          end
        end else if (!down) begin
          run[i]++;
          if (run[i] == DB) begin
            lvl[i] = 1'b0; run[i] = 0; nr[i] = 1'b1;
          end
        end else if (run[i] > 0) begin
          run[i]  = 0;
          hold[i] = 0;
        end else if (hold[i] < LG) begin
          hold[i]++;
          if (hold[i] == LG) nl[i] = 1'b1;
        end
      end
      smp2 = smp1;
      smp1 = bus.key_in;
      ep   = np;
      if ((np | nr | nl) != '0) q.push_back('{cyc, np, nr, nl});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int            cnt_p[NK];
  int            cnt_r[NK];
  int            cnt_l[NK];
  int            sflat;
  logic [NK-1:0] dp, dr, dl;
  ev_t           ev;

  always @(negedge clk) begin
    sflat = 0;
    for (int i = 0; i < NK; i++) sflat |= esum[i] << (i * CW);
    check("key_state", int'(bus.key_state), int'(lvl));
    check("sum", int'(bus.sum), sflat);
    dp = bus.press_pulse;
    dr = bus.release_pulse;
    dl = bus.long_pulse;
    if (!rst_n) begin
      check("reset_pulses", int'({dp, dr, dl}), 0);
    end else begin
      for (int i = 0; i < NK; i++) begin
        cnt_p[i] += int'(dp[i]);
        cnt_r[i] += int'(dr[i]);
        cnt_l[i] += int'(dl[i]);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL sb_missing: event of cycle %0d never seen, got none, want p=%b r=%b l=%b",
                 q[0].cyc, q[0].p, q[0].r, q[0].l);
        void'(q.pop_front());
      end
      if ((dp | dr | dl) != '0) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          total++; bad++;
          $display("FAIL sb_unexpected: cycle %0d got p=%b r=%b l=%b, want no event", cyc, dp, dr, dl);
        end else begin
          ev = q.pop_front();
          check("sb_press",   int'(dp), int'(ev.p));
          check("sb_release", int'(dr), int'(ev.r));
          check("sb_long",    int'(dl), int'(ev.l));
        end
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        total++; bad++;
        $display("FAIL sb_missing: cycle %0d got none, want p=%b r=%b l=%b", cyc, q[0].p, q[0].r, q[0].l);
        void'(q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next_drive();
  endtask

  // Counts edges until the chosen strobe of key idx shows; 0 means timeout.
  task automatic wait_ev(input int kind, input int idx, input int bound,
                         output int n, output logic [NK-1:0] snap);
    n    = 0;
    snap = '0;
    for (int k = 1; k <= bound; k++) begin
      @(posedge clk);
      @(negedge clk);
      if ((kind == 0 && bus.press_pulse[idx]) ||
          (kind == 1 && bus.release_pulse[idx]) ||
          (kind == 2 && bus.long_pulse[idx])) begin
        n    = k;
        snap = bus.press_pulse;
        break;
      end
    end
  endtask

  int            n;
  logic [NK-1:0] snap;
  int            rem[NK];

  initial begin
    for (int i = 0; i < NK; i++) begin
      cnt_p[i] = 0; cnt_r[i] = 0; cnt_l[i] = 0;
      run[i] = 0; hold[i] = 0; esum[i] = 0;
    end
    bus.key_in  = '1;
    bus.clr_sum = '0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // 1: clean short press on key0
    bus.key_in[0] = 1'b0;
    wait_ev(0, 0, 30, n, snap);
    check("t1_press_latency", n, DB + 2);
    idle(5);
    bus.key_in[0] = 1'b1;
    wait_ev(1, 0, 30, n, snap);
    check("t1_release_latency", n, DB + 2);
    next_drive();
    check("t1_press_count", cnt_p[0], 1);
    check("t1_long_count", cnt_l[0], 0);
    check("t1_sum0", int'(bus.sum[0 +: CW]), 1);

    // 2: bouncing key1, low runs shorter than the debounce window
    for (int k = 0; k < 10; k++) begin
      bus.key_in[1] = 1'b0;
      idle(3);
      bus.key_in[1] = 1'b1;
      idle(3);
    end
    idle(6);
    check("t2_press_count", cnt_p[1], 0);
    check("t2_sum1", int'(bus.sum[CW +: CW]), 0);

    // 3: long hold on key2
    bus.key_in[2] = 1'b0;
    wait_ev(0, 2, 30, n, snap);
    check("t3_press_latency", n, DB + 2);
    wait_ev(2, 2, 40, n, snap);
    check("t3_long_after_press", n, LG);
    idle(30);
    check("t3_long_count", cnt_l[2], 1);
    bus.key_in[2] = 1'b1;
    wait_ev(1, 2, 30, n, snap);
    check("t3_release_latency", n, DB + 2);
    next_drive();

    // 4: counter wrap on key3, then a clear landing on the 18th press
    for (int k = 1; k <= 17; k++) begin
      bus.key_in[3] = 1'b0;
      idle(8);
      bus.key_in[3] = 1'b1;
      idle(8);
      check("t4_sum3", int'(bus.sum[3*CW +: CW]), k % 16);
    end
    bus.key_in[3] = 1'b0;
    idle(7);
    check("t4_press_visible", int'(bus.press_pulse[3]), 1);
    bus.clr_sum[3] = 1'b1;
    next_drive();
    bus.clr_sum[3] = 1'b0;
    check("t4_clr_with_press", int'(bus.sum[3*CW +: CW]), 1);
    bus.key_in[3] = 1'b1;
    idle(10);

    // 5: keys 0 and 1 pressed on the same edge
    bus.key_in[1:0] = 2'b00;
    wait_ev(0, 0, 30, n, snap);
    check("t5_press_latency", n, DB + 2);
    check("t5_press_vector", int'(snap), 4'b0011);
    next_drive();
    check("t5_sum0", int'(bus.sum[0 +: CW]), 2);
    check("t5_sum1", int'(bus.sum[CW +: CW]), 1);
    check("t5_sum3", int'(bus.sum[3*CW +: CW]), 1);
    bus.key_in[1:0] = 2'b11;
    idle(10);

    // 6: reset with key1 pressed and key0 mid-debounce
    bus.key_in[1] = 1'b0;
    idle(10);
    bus.key_in[0] = 1'b0;
    idle(5);
    rst_n = 1'b0;
    #1;
    check("t6_reset_state", int'(bus.key_state), 0);
    check("t6_reset_sum", int'(bus.sum), 0);
    idle(3);
    rst_n = 1'b1;
    wait_ev(0, 0, 30, n, snap);
    check("t6_reaccept_latency", n, DB + 2);
    check("t6_reaccept_vector", int'(snap[1:0]), 2'b11);
    next_drive();
    bus.key_in[1:0] = 2'b11;
    idle(10);

    // random traffic on all keys with occasional clears
    for (int i = 0; i < NK; i++) rem[i] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NK; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          bus.key_in[i] = ~bus.key_in[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 40);
        end
        bus.clr_sum[i] = ($urandom_range(0, 31) == 0);
      end
      next_drive();
    end
    bus.key_in  = '1;
    bus.clr_sum = '0;
    idle(15);
    check("final_key_state", int'(bus.key_state), 0);
    check("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
